l2_arbiter: RTL and testbench
=============================

Name: l2_arbiter

Overview:
- Shares the single unified L2 cache port between the L1 instruction cache (read-only) and the L1 data cache (read/write), one line transaction at a time.
- Sits between the two L1 miss interfaces and the L2 cache's mem_read/mem_write/mem_resp interface.
- Latches the granted request and holds it stable on the L2 port until completion.
- Resolves simultaneous misses with round-robin priority, so neither requester waits more than one foreign transaction.

Parameters:
ADDR_W, 32, byte address width of line requests
LINE_W, 256, cache line width in bits

Ports:
clk  input  1  system clock, all state updates on posedge
rst_n  input  1  synchronous active-low reset
icache_read  input  1  I-cache line read request, held until icache_resp
icache_addr  input  ADDR_W  I-cache request address
icache_rdata  output  LINE_W  line returned to I-cache
icache_resp  output  1  one-cycle completion pulse to I-cache
dcache_read  input  1  D-cache line read request, held until dcache_resp
dcache_write  input  1  D-cache line writeback request, held until dcache_resp
dcache_addr  input  ADDR_W  D-cache request address
dcache_wdata  input  LINE_W  D-cache writeback line
dcache_rdata  output  LINE_W  line returned to D-cache
dcache_resp  output  1  one-cycle completion pulse to D-cache
l2_read  output  1  read request to L2
l2_write  output  1  write request to L2
l2_addr  output  ADDR_W  address to L2
l2_wdata  output  LINE_W  write line to L2
l2_rdata  input  LINE_W  line from L2
l2_resp  input  1  L2 completion pulse

Behaviour:
- Clock and reset: one clock (clk). rst_n is synchronous and active-low.
- Internal state:
  - FSM states: IDLE, SERVE_I, SERVE_D.
  - last_grant flag (I or D).
  - Latched registers: req_addr, req_wdata, req_is_write.
- Reset, taking effect at the posedge sampling rst_n=0:
  - state=IDLE, last_grant=I, latched registers cleared.
  - In the cycle after that edge: l2_read=l2_write=0, icache_resp=dcache_resp=0, l2_addr=0, l2_wdata=0.
  - Reset mid-transaction abandons the transaction: no resp pulse is ever issued for it, and L2 sees its strobe drop after the reset edge.
- IDLE:
  - All outputs deasserted; l2_resp is ignored.
  - I-pending = icache_read. D-pending = dcache_read | dcache_write.
  - Only I pending: go to SERVE_I and latch icache_addr with req_is_write=0.
  - Only D pending: go to SERVE_D and latch dcache_addr, dcache_wdata, and req_is_write=dcache_write.
  - Both pending: grant the requester that is not last_grant. After reset, D wins the first tie.
  - On grant, last_grant is updated to the granted requester.
- SERVE_I / SERVE_D:
  - l2_addr=req_addr and l2_wdata=req_wdata, both from registers.
  - l2_read=!req_is_write and l2_write=req_is_write, held continuously until l2_resp.
  - Requester inputs are not re-sampled. Deassertion or change of the request mid-transaction does not abort it, and the resp pulse is still issued.
  - On l2_resp=1: the granted requester's resp=1 in the same cycle (combinational from l2_resp and state), and the FSM goes to IDLE at the next edge.
  - The non-granted resp stays 0 throughout.
- Read data: icache_rdata and dcache_rdata are both wired to l2_rdata and are valid only when the matching resp=1.
- Latency:
  - Request seen in IDLE at edge N: L2 strobe asserted in the cycle after edge N.
  - Requester resp is coincident with l2_resp.
  - Minimum one IDLE cycle between consecutive transactions, giving the L1 a cycle to drop its request after resp.
- dcache_read and dcache_write both high: write takes precedence (req_is_write=1).
- Fairness: with both requesters continuously pending, grants alternate I/D/I/D…, and no requester waits more than one foreign transaction.
- l2_resp in IDLE, or any stray l2_resp: no effect.
- Unused/undefined state encodings recover to IDLE.

Test Plan:
- Reset, then icache_read=1, icache_addr=0x0000_1040; L2 returns l2_resp after 5 cycles with l2_rdata=0xA5…A5 -> l2_read=1 and l2_addr=0x1040 for exactly those cycles; icache_resp=1 for 1 cycle with icache_rdata=0xA5…A5; dcache_resp stays 0.
- dcache_write=1, dcache_addr=0x2000, dcache_wdata=0x1234…; mid-transaction the bench changes dcache_addr to 0x3000 -> l2_write=1 with l2_addr held at 0x2000 and l2_wdata=0x1234…; dcache_resp pulses once.
- After reset, icache_read and dcache_read asserted in the same cycle and held across completions -> grant order D, I, D, I, with one IDLE cycle between transactions and each resp a single-cycle pulse.
- rst_n=0 for one cycle while in SERVE_I, 2 cycles before l2_resp -> l2_read=0 in the following cycle; later l2_resp causes no icache_resp; the next icache_read is served normally.
- Stray l2_resp=1 in IDLE -> no resp outputs and state stays IDLE. dcache_read=dcache_write=1 -> l2_write=1, l2_read=0.

Source files
------------

// File: rtl/l2_arbiter.sv
// ---------------------------------------------------------------------------
// l2_arbiter
//
// Shares the single unified L2 cache port between the L1 instruction cache
// (read-only) and the L1 data cache (read/write), one line transaction at a
// time. Simultaneous misses are resolved round-robin, so neither requester
// ever waits behind more than one foreign transaction. The granted request
// is latched and held stable on the L2 port until l2_resp.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   icache_read, icache_addr       I-cache line read request (held to resp)
//   icache_rdata, icache_resp      line + one-cycle completion to I-cache
//   dcache_read, dcache_write      D-cache read / writeback request
//   dcache_addr, dcache_wdata      D-cache request address / writeback line
//   dcache_rdata, dcache_resp      line + one-cycle completion to D-cache
//   l2_read, l2_write              request strobes to L2
//   l2_addr, l2_wdata              latched address / write line to L2
//   l2_rdata, l2_resp              line + completion pulse from L2
// ---------------------------------------------------------------------------
module l2_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_addr,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,

    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,

    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            state;
    logic              last_grant_d;   // 1: D-cache was granted last, 0: I-cache
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic              req_is_write;
    logic              l2_read_q;
    logic              l2_write_q;

    logic              i_pend;
    logic              d_pend;
    logic              grant_d;
    logic              serving;

    // Arbitration: D wins when it is the only one pending, or on a tie when
    // the I-cache was granted last.
    always_comb begin
        i_pend  = icache_read;
        d_pend  = dcache_read | dcache_write;
        grant_d = d_pend & (~i_pend | ~last_grant_d);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Abandons any in-flight transaction: the strobe drops and no
            // resp can follow, because resp is decoded from the SERVE states.
            state        <= IDLE;
            last_grant_d <= 1'b0;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_is_write <= 1'b0;
            l2_read_q    <= 1'b0;
            l2_write_q   <= 1'b0;
        end else begin
            // NOTE: the default arm sends unused encodings back to IDLE, and
            // every arm assigns only what it means to change.
            case (state)
                IDLE: begin
                    if (i_pend || d_pend) begin
                        if (grant_d) begin
                            state        <= SERVE_D;
                            last_grant_d <= 1'b1;
                            req_addr     <= dcache_addr;
                            req_wdata    <= dcache_wdata;
                            // Write takes precedence when both strobes are high.
                            req_is_write <= dcache_write;
                            l2_read_q    <= ~dcache_write;
                            l2_write_q   <= dcache_write;
                        end else begin
                            state        <= SERVE_I;
                            last_grant_d <= 1'b0;
                            req_addr     <= icache_addr;
                            req_wdata    <= '0;
                            req_is_write <= 1'b0;
                            l2_read_q    <= 1'b1;
                            l2_write_q   <= 1'b0;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Requester inputs are deliberately not looked at here.
                    if (l2_resp) begin
                        state      <= IDLE;
                        l2_read_q  <= 1'b0;
                        l2_write_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    l2_read_q  <= 1'b0;
                    l2_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign serving  = (state == SERVE_I) || (state == SERVE_D);

    assign l2_read  = l2_read_q;
    assign l2_write = l2_write_q;
    assign l2_addr  = serving ? req_addr  : '0;
    assign l2_wdata = serving ? req_wdata : '0;

    // Completion is passed straight through so the L1 sees it in the same
    // cycle as the L2.
    assign icache_resp  = (state == SERVE_I) & l2_resp;
    assign dcache_resp  = (state == SERVE_D) & l2_resp;
    assign icache_rdata = l2_rdata;
    assign dcache_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2_arbiter
//
// Directed scenarios followed by randomized transactions for l2_arbiter.
// The bench plays both L1 caches and the L2. Expected grants come from a
// transaction-level round-robin model (who asked, who was served last), and
// the expected L2 command is the request as presented at grant time.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_l2_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk;
    logic              rst_n;
    logic              icache_read;
    logic [ADDR_W-1:0] icache_addr;
    logic [LINE_W-1:0] icache_rdata;
    logic              icache_resp;
    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_addr;
    logic [LINE_W-1:0] dcache_wdata;
    logic [LINE_W-1:0] dcache_rdata;
    logic              dcache_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: which requester the round-robin served most recently.
    bit exp_last_d = 1'b0;

    l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .icache_read  (icache_read),
        .icache_addr  (icache_addr),
        .icache_rdata (icache_rdata),
        .icache_resp  (icache_resp),
        .dcache_read  (dcache_read),
        .dcache_write (dcache_write),
        .dcache_addr  (dcache_addr),
        .dcache_wdata (dcache_wdata),
        .dcache_rdata (dcache_rdata),
        .dcache_resp  (dcache_resp),
        .l2_read      (l2_read),
        .l2_write     (l2_write),
        .l2_addr      (l2_addr),
        .l2_wdata     (l2_wdata),
        .l2_rdata     (l2_rdata),
        .l2_resp      (l2_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " l2_read"},     l2_read,     1'b0);
        check({tag, " l2_write"},    l2_write,    1'b0);
        check({tag, " icache_resp"}, icache_resp, 1'b0);
        check({tag, " dcache_resp"}, dcache_resp, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("reset");
        check("reset l2_addr",  l2_addr,  '0);
        check("reset l2_wdata", l2_wdata, '0);
        exp_last_d = 1'b0;
        tick();
    endtask

    // One complete transaction starting in an IDLE cycle with no requests
    // outstanding. The requests are perturbed after the grant to show they
    // are not re-sampled, and dropped after resp.
    task automatic run_txn(input string tag, input bit i_req, input bit d_rd,
                           input bit d_wr, input logic [ADDR_W-1:0] ia,
                           input logic [ADDR_W-1:0] da,
                           input logic [LINE_W-1:0] wd,
                           input logic [LINE_W-1:0] rd, input int lat,
                           input bit stray, input bit mutate);
        bit                win_d;
        bit                exp_wr;
        logic [ADDR_W-1:0] exp_addr;
        logic [LINE_W-1:0] exp_wdata;

        win_d      = (d_rd || d_wr) && (!i_req || !exp_last_d);
        exp_last_d = win_d;
        exp_wr     = win_d && d_wr;
        exp_addr   = win_d ? da : ia;
        exp_wdata  = wd;

        icache_read  = i_req;
        icache_addr  = ia;
        dcache_read  = d_rd;
        dcache_write = d_wr;
        dcache_addr  = da;
        dcache_wdata = wd;
        l2_resp      = stray;
        l2_rdata     = rd;
        @(negedge clk);
        check_quiet({tag, " idle"});
        tick();
        l2_resp = 1'b0;

        if (mutate) begin
            icache_addr  = ~ia;
            dcache_addr  = da ^ 32'h0000_1000;
            dcache_wdata = ~wd;
            icache_read  = 1'($urandom_range(0, 1));
            dcache_read  = 1'($urandom_range(0, 1));
            dcache_write = 1'($urandom_range(0, 1));
        end

        for (int k = 0; k <= lat; k++) begin
            if (k == lat) begin
                l2_resp  = 1'b1;
                l2_rdata = rd;
            end
            @(negedge clk);
            check({tag, " l2_read"},  l2_read,  !exp_wr);
            check({tag, " l2_write"}, l2_write, exp_wr);
            check({tag, " l2_addr"},  l2_addr,  exp_addr);
            if (win_d)
                check({tag, " l2_wdata"}, l2_wdata, exp_wdata);
            check({tag, " icache_resp"}, icache_resp, (k == lat) && !win_d);
            check({tag, " dcache_resp"}, dcache_resp, (k == lat) && win_d);
            if (k == lat)
                check({tag, " rdata"}, win_d ? dcache_rdata : icache_rdata, rd);
            tick();
        end

        l2_resp      = 1'b0;
        icache_read  = 1'b0;
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        @(negedge clk);
        check_quiet({tag, " after"});
        tick();
    endtask

    initial begin
        logic [LINE_W-1:0] pat_a5;
        logic [LINE_W-1:0] pat_12;
        logic [LINE_W-1:0] rnd_line;
        logic [LINE_W-1:0] rnd_data;
        bit                win_d;

        pat_a5 = {32{8'hA5}};
        pat_12 = {16{16'h1234}};

        rst_n        = 1'b0;
        icache_read  = 1'b0;
        icache_addr  = '0;
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        dcache_addr  = '0;
        dcache_wdata = '0;
        l2_rdata     = '0;
        l2_resp      = 1'b0;

        // Step 1: reset, then a single I-cache miss with a 5-cycle L2.
        do_reset();
        run_txn("icache_rd", 1'b1, 1'b0, 1'b0, 32'h0000_1040, 32'h0,
                '0, pat_a5, 5, 1'b0, 1'b0);

        // Step 2: D-cache writeback; address moves to 0x3000 mid-flight.
        run_txn("dcache_wr", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_2000,
                pat_12, '0, 3, 1'b0, 1'b1);

        // Step 3: both requesters held continuously after reset: D, I, D, I.
        do_reset();
        icache_read = 1'b1;
        icache_addr = 32'h0000_A000;
        dcache_read = 1'b1;
        dcache_addr = 32'h0000_D000;
        for (int t = 0; t < 4; t++) begin
            win_d      = !exp_last_d;
            exp_last_d = win_d;
            @(negedge clk);
            check_quiet("rr idle");
            tick();
            @(negedge clk);
            check("rr l2_read", l2_read, 1'b1);
            check("rr l2_addr", l2_addr, win_d ? 32'h0000_D000 : 32'h0000_A000);
            tick();
            l2_resp  = 1'b1;
            l2_rdata = {8{32'(t) + 32'hC0DE_0000}};
            @(negedge clk);
            check("rr icache_resp", icache_resp, !win_d);
            check("rr dcache_resp", dcache_resp, win_d);
            tick();
            l2_resp = 1'b0;
        end
        icache_read = 1'b0;
        dcache_read = 1'b0;
        @(negedge clk);
        check_quiet("rr end");
        tick();

        // Step 4: reset while serving I, two cycles before the L2 answers.
        icache_read = 1'b1;
        icache_addr = 32'h0000_5540;
        @(negedge clk);
        check("rst_mid idle l2_read", l2_read, 1'b0);
        tick();
        @(negedge clk);
        check("rst_mid serve l2_read", l2_read, 1'b1);
        tick();
        rst_n       = 1'b0;
        icache_read = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_last_d = 1'b0;
        @(negedge clk);
        check("rst_mid l2_read", l2_read, 1'b0);
        check("rst_mid l2_addr", l2_addr, '0);
        tick();
        l2_resp = 1'b1;
        @(negedge clk);
        check("rst_mid late icache_resp", icache_resp, 1'b0);
        check("rst_mid late dcache_resp", dcache_resp, 1'b0);
        tick();
        l2_resp = 1'b0;
        run_txn("rst_mid next", 1'b1, 1'b0, 1'b0, 32'h0000_5580, 32'h0,
                '0, ~pat_a5, 2, 1'b0, 1'b0);

        // Step 5: stray l2_resp in IDLE, then read+write together.
        l2_resp = 1'b1;
        @(negedge clk);
        check_quiet("stray 0");
        tick();
        @(negedge clk);
        check_quiet("stray 1");
        tick();
        l2_resp = 1'b0;
        @(negedge clk);
        check_quiet("stray after");
        tick();
        run_txn("rd_wr both", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_7000,
                ~pat_12, pat_a5, 1, 1'b0, 1'b0);

        // Step 6: randomized transactions against the round-robin model.
        for (int n = 0; n < 40; n++) begin
            bit ir;
            bit dr;
            bit dw;
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            if (!ir && !dr && !dw)
                ir = 1'b1;
            for (int w = 0; w < LINE_W / 32; w++) begin
                rnd_line[w*32 +: 32] = $urandom;
                rnd_data[w*32 +: 32] = $urandom;
            end
            run_txn($sformatf("rand%0d", n), ir, dr, dw, $urandom, $urandom,
                    rnd_line, rnd_data, int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
